fifo_sync: RTL
==============

# fifo_sync

Synchronous first-word-fall-through FIFO that buffers bytes between the UART receiver/transmitter and the client logic that consumes or produces them. It is the responder for the `rd`/`r_data`/`rx_empty` and `wr`/`w_data`/`tx_full` handshakes that client FSMs drive. Two instances are used: one on the RX path, with `empty` driving the client's `rx_empty`, and one on the TX path, with `full` driving the client's `tx_full`.

## Interface
- `B`, 8, data width in bits
- `W`, 2, address width; depth = 2^W entries

- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `wr`  input  1  push request; `w_data` is sampled on the same edge
- `w_data`  input  B  data to push
- `rd`  input  1  pop request; removes the head entry
- `r_data`  output  B  head entry; valid whenever `empty`=0
- `empty`  output  1  FIFO holds 0 entries
- `full`  output  1  FIFO holds 2^W entries
- `count`  output  W+1  number of stored entries, 0..2^W
- `overflow`  output  1  sticky flag: a write was dropped because the FIFO was full
- `underflow`  output  1  sticky flag: a read was ignored because the FIFO was empty

## Operation
- **Storage**
  - 2^W × B register array.
  - Write pointer `wp` and read pointer `rp`, each W bits, both wrapping modulo 2^W.
  - `count` is a W+1-bit register.
- **Output path**
  - `r_data` = `mem[rp]`, combinational from registered state.
  - No read latency: the head entry is presented before `rd` is asserted.
- **Effective operations**, evaluated each rising edge with `reset`=0:
  - `do_wr` = `wr` & (~`full` | `rd`)
  - `do_rd` = `rd` & ~`empty`
- **Case rules**
  - `do_wr` only: `mem[wp]`←`w_data`; `wp`+1; `count`+1.
  - `do_rd` only: `rp`+1; `count`−1.
  - Both: write and read in the same cycle; both pointers advance; `count`, `empty` and `full` are unchanged.
  - `wr` while `full` with `rd`=0: write dropped; storage and pointers unchanged; `overflow`←1.
  - `rd` while `empty`: read ignored; `underflow`←1. A simultaneous `wr` is still accepted, and `r_data` shows the new word on the next cycle.
- **Flags**
  - `empty` and `full` are registers, updated on the same edge as `count`.
  - `empty` = (next `count` == 0); `full` = (next `count` == 2^W).
- **Sticky flags**
  - `overflow` and `underflow` stay set until `reset`.
- **Reset**
  - Clears `wp`, `rp`, `count`, `overflow`, `underflow`.
  - After reset: `empty`=1, `full`=0, `count`=0.
  - The storage array is not reset, so `r_data` is don't-care while `empty`=1.
  - Reset asserted mid-operation discards all contents on that edge, regardless of `rd`/`wr`.
  - `reset` has priority over `rd`/`wr`.

## Timing
- **Write to read**
  - A word written on edge k appears on `r_data` after edge k.
  - `empty` deasserts after edge k, and the consumer can pop on edge k+1.
  - Minimum latency from `wr` to a visible head is 1 cycle.
- **Pop**
  - `rd` on edge k advances `r_data` to the next entry after edge k.
  - One pop per cycle is sustained at full throughput.
- **Flag timing**
  - `full` asserts on the edge that stores entry 2^W.
  - `full` deasserts on the edge of the first pop, so a producer may write again on the following edge.
- **Handshake**
  - Producers and consumers are single-cycle pulse or level based; each asserted cycle is one operation.
  - Clients must sample `empty`/`full` before asserting `rd`/`wr`.
  - The FIFO tolerates violations via the drop/ignore rules above.
- **Wrap-around**
  - Pointers roll over from 2^W−1 to 0 with no gap.
  - Data order is preserved across the wrap.

## Test plan
- **Reset defaults:** assert `reset` for 2 cycles → `empty`=1, `full`=0, `count`=0, `overflow`=0, `underflow`=0.
- **Fill and drain:** with W=2, write 0x11, 0x22, 0x33, 0x44 on consecutive cycles → `full`=1 and `count`=4 after the 4th edge. A 5th write of 0x55 → dropped, `overflow`=1. Then pop 4 times → `r_data` reads 0x11, 0x22, 0x33, 0x44, then `empty`=1.
- **Pop when empty:** pulse `rd` while `empty` → `underflow`=1, `count` stays 0. Assert `rd`+`wr` (0xA5) while empty → `count`=1, `r_data`=0xA5, `empty`=0 on the next cycle.
- **Simultaneous read and write when full:** FIFO full with 0x01..0x04; `rd`+`wr` with 0x05 → `count`=4, `full`=1, `r_data`=0x02. Draining then yields 0x02, 0x03, 0x04, 0x05.
- **Wrap-around:** 10 interleaved write/read pairs of 0x30..0x39 at 1-deep occupancy → each `r_data` matches its write one cycle later across two pointer wraps.
- **Mid-operation reset:** with 3 entries stored, assert `reset` together with `wr`=1 → `count`=0, `empty`=1, and the write is not stored.

Source files
------------

// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through byte FIFO with registered empty/full flags
// and sticky overflow/underflow indicators.
module fifo_sync #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int unsigned Depth = 2 ** W;

  logic [B-1:0] mem_q [Depth];
  logic [W-1:0] wp_q, wp_d;
  logic [W-1:0] rp_q, rp_d;
  logic [W:0]   count_q, count_d;
  logic         empty_q, empty_d;
  logic         full_q, full_d;
  logic         overflow_q, overflow_d;
  logic         underflow_q, underflow_d;
  logic         do_wr, do_rd;

  // A pop frees a slot on the same edge, so a write alongside a pop is accepted even when full.
  assign do_wr = wr & (~full_q | rd);
  assign do_rd = rd & ~empty_q;

  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (wr & full_q & ~rd);
    underflow_d = underflow_q | (rd & empty_q);
    if (do_wr) begin
      wp_d = wp_q + W'(1);
    end
    if (do_rd) begin
      rp_d = rp_q + W'(1);
    end
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (W + 1)'(1);
      2'b01:   count_d = count_q - (W + 1)'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == (W + 1)'(Depth));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset; contents are only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) begin
      mem_q[wp_q] <= w_data;
    end
  end

  assign r_data    = mem_q[rp_q];
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
